// File: rtl/pmb_sel_pipe.sv
// Channel select with optional data-background inversion, carried through a DEPTH-stage valid/ready pipeline.
// Latency DEPTH cycles, one word per cycle; a stalled output only blocks input once every stage is full (bubbles collapse).
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif

module pmb_sel_pipe #(
    parameter int DW    = `DATA_WIDTH,
    parameter int NCH   = 4,
    parameter int SELW  = 2,
    parameter int DEPTH = 2,
    parameter int CW    = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NCH*DW-1:0] ch_data_in,
    input  logic [SELW-1:0]   sel_in,
    input  logic              inv_in,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              flush_in,
    output logic [DW-1:0]     d_out,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CW-1:0]     occ_out,
    output logic              err_out
);

    logic [DEPTH-1:0]         v_q, v_d;
    logic [DEPTH-1:0][DW-1:0] q_q, q_d;
    logic                     err_q, err_d;

    logic [DEPTH-1:0]         adv;
    logic                     all_full;
    logic [DW-1:0]            word_sel;
    logic [DW-1:0]            new_word;
    logic                     sel_ok;
    logic                     accept;
    logic [CW-1:0]            occ;

    // Out-of-range selects fall through as zero before inversion.
    always_comb begin
        word_sel = '0;
        sel_ok   = 1'b0;
        for (int k = 0; k < NCH; k++) begin
            if (sel_in == SELW'(k)) begin
                word_sel = ch_data_in[k*DW +: DW];
                sel_ok   = 1'b1;
            end
        end
        new_word = word_sel ^ {DW{inv_in}};
    end

    // A stage may advance if it or any later stage has room, or the output drains.
    always_comb begin
        all_full = 1'b1;
        adv      = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            all_full = all_full & v_q[i];
            adv[i]   = ~all_full | out_ready;
        end
    end

    assign in_ready = adv[0] & ~flush_in;
    assign accept   = in_valid & in_ready;

    always_comb begin
        v_d   = v_q;
        q_d   = q_q;
        err_d = err_q;
        if (flush_in) begin
            v_d = '0;
        end else begin
            for (int i = 1; i < DEPTH; i++) begin
                if (adv[i]) begin
                    v_d[i] = v_q[i-1];
                    q_d[i] = q_q[i-1];
                end
            end
            if (adv[0]) begin
                v_d[0] = accept;
                if (accept) begin
                    q_d[0] = new_word;
                end
            end
            if (accept && !sel_ok) begin
                err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            v_q   <= '0;
            q_q   <= '0;
            err_q <= 1'b0;
        end else begin
            v_q   <= v_d;
            q_q   <= q_d;
            err_q <= err_d;
        end
    end

    always_comb begin
        occ = '0;
        for (int i = 0; i < DEPTH; i++) begin
            occ = occ + CW'(v_q[i]);
        end
    end

    assign occ_out   = occ;
    assign d_out     = q_q[DEPTH-1];
    assign out_valid = v_q[DEPTH-1];
    assign err_out   = err_q;

endmodule

// File: tb/tb_pmb_sel_pipe.sv
// Bench for pmb_sel_pipe: a 4-channel and a 3-channel instance share stimulus, each with its own scoreboard.
module tb_pmb_sel_pipe;

    logic        clk;
    logic        rst;
    logic [1:0]  sel_in;
    logic        inv_in;
    logic        in_valid;
    logic        flush_in;
    logic        out_ready;

    logic [7:0]  chv [4];
    logic [31:0] ch4;
    logic [23:0] ch3;

    logic        rdy4, ov4, err4;
    logic [7:0]  d4;
    logic [1:0]  occ4;
    logic        rdy3, ov3, err3;
    logic [7:0]  d3;
    logic [1:0]  occ3;

    logic [7:0]  q4 [$];
    logic [7:0]  q3 [$];

    int n_cmp;
    int n_fail;

    assign ch4 = {chv[3], chv[2], chv[1], chv[0]};
    assign ch3 = {chv[2], chv[1], chv[0]};

    pmb_sel_pipe #(.DW(8), .NCH(4), .SELW(2), .DEPTH(2), .CW(2)) dut4 (
        .clk(clk), .rst(rst), .ch_data_in(ch4), .sel_in(sel_in), .inv_in(inv_in),
        .in_valid(in_valid), .in_ready(rdy4), .flush_in(flush_in), .d_out(d4),
        .out_valid(ov4), .out_ready(out_ready), .occ_out(occ4), .err_out(err4)
    );

    pmb_sel_pipe #(.DW(8), .NCH(3), .SELW(2), .DEPTH(2), .CW(2)) dut3 (
        .clk(clk), .rst(rst), .ch_data_in(ch3), .sel_in(sel_in), .inv_in(inv_in),
        .in_valid(in_valid), .in_ready(rdy3), .flush_in(flush_in), .d_out(d3),
        .out_valid(ov3), .out_ready(out_ready), .occ_out(occ3), .err_out(err3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] model(input int nch, input int sel, input logic inv);
        logic [7:0] w;
        w = (sel < nch) ? chv[sel] : 8'h00;
        return w ^ {8{inv}};
    endfunction

    // Samples handshakes at the falling edge, then returns 1 time unit after the rising edge.
    task automatic step();
        logic [7:0] e;
        @(negedge clk);
        if (rst) begin
            if (flush_in) begin
                q4.delete();
                q3.delete();
            end else begin
                if (in_valid && rdy4) q4.push_back(model(4, int'(sel_in), inv_in));
                if (in_valid && rdy3) q3.push_back(model(3, int'(sel_in), inv_in));
                if (ov4 && out_ready) begin
                    n_cmp++;
                    if (q4.size() == 0) begin
                        n_fail++;
                        $display("FAIL sb4_underflow: got word %h, expected no output", d4);
                    end else begin
                        e = q4.pop_front();
                        if (d4 !== e) begin
                            n_fail++;
                            $display("FAIL sb4_data: got %h, expected %h", d4, e);
                        end
                    end
                end
                if (ov3 && out_ready) begin
                    n_cmp++;
                    if (q3.size() == 0) begin
                        n_fail++;
                        $display("FAIL sb3_underflow: got word %h, expected no output", d3);
                    end else begin
                        e = q3.pop_front();
                        if (d3 !== e) begin
                            n_fail++;
                            $display("FAIL sb3_data: got %h, expected %h", d3, e);
                        end
                    end
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst       = 1'b0;
        in_valid  = 1'b0;
        flush_in  = 1'b0;
        out_ready = 1'b0;
        sel_in    = 2'd0;
        inv_in    = 1'b0;
        q4.delete();
        q3.delete();
        step();
        step();
        rst = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++; if (d4 !== 8'h00)   begin n_fail++; $display("FAIL reset_d_out: got %h, expected 00", d4); end
        n_cmp++; if (ov4 !== 1'b0)   begin n_fail++; $display("FAIL reset_out_valid: got %b, expected 0", ov4); end
        n_cmp++; if (occ4 !== 2'd0)  begin n_fail++; $display("FAIL reset_occ: got %0d, expected 0", occ4); end
        n_cmp++; if (err4 !== 1'b0)  begin n_fail++; $display("FAIL reset_err: got %b, expected 0", err4); end
        n_cmp++; if (rdy4 !== 1'b1)  begin n_fail++; $display("FAIL reset_in_ready: got %b, expected 1", rdy4); end
        n_cmp++; if (err3 !== 1'b0)  begin n_fail++; $display("FAIL reset_err3: got %b, expected 0", err3); end
    endtask

    task automatic test_streaming();
        logic [7:0] exp_w [4];
        exp_w[0] = 8'h11; exp_w[1] = 8'h22; exp_w[2] = 8'hCC; exp_w[3] = 8'h44;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            sel_in   = 2'(i);
            inv_in   = (i == 2);
            in_valid = 1'b1;
            step();
            n_cmp++;
            if (ov4 !== (i >= 1)) begin
                n_fail++;
                $display("FAIL stream_valid_%0d: got %b, expected %b", i, ov4, (i >= 1));
            end
            if (i >= 1) begin
                n_cmp++;
                if (d4 !== exp_w[i-1]) begin
                    n_fail++;
                    $display("FAIL stream_data_%0d: got %h, expected %h", i, d4, exp_w[i-1]);
                end
            end
        end
        in_valid = 1'b0;
        inv_in   = 1'b0;
        step();
        n_cmp++; if (d4 !== 8'h44) begin n_fail++; $display("FAIL stream_last: got %h, expected 44", d4); end
        step();
        n_cmp++; if (ov4 !== 1'b0) begin n_fail++; $display("FAIL stream_drained: got %b, expected 0", ov4); end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            sel_in = 2'(i);
            step();
        end
        n_cmp++; if (rdy4 !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready: got %b, expected 0", rdy4); end
        n_cmp++; if (occ4 !== 2'd2) begin n_fail++; $display("FAIL bp_occ: got %0d, expected 2", occ4); end
        n_cmp++; if (d4 !== 8'h11)  begin n_fail++; $display("FAIL bp_hold: got %h, expected 11", d4); end
        out_ready = 1'b1;
        #1;
        n_cmp++; if (rdy4 !== 1'b1) begin n_fail++; $display("FAIL bp_ready_chain: got %b, expected 1", rdy4); end
        step();
        out_ready = 1'b0;
        in_valid  = 1'b0;
        n_cmp++; if (occ4 !== 2'd2) begin n_fail++; $display("FAIL bp_occ_swap: got %0d, expected 2", occ4); end
        n_cmp++; if (d4 !== 8'h22)  begin n_fail++; $display("FAIL bp_retire: got %h, expected 22", d4); end
        step();
        n_cmp++; if (d4 !== 8'h22)  begin n_fail++; $display("FAIL bp_stall_hold: got %h, expected 22", d4); end
        out_ready = 1'b1;
        step();
        step();
        n_cmp++; if (occ4 !== 2'd0) begin n_fail++; $display("FAIL bp_drain: got %0d, expected 0", occ4); end
    endtask

    task automatic test_bubble();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        sel_in    = 2'd1;
        inv_in    = 1'b0;
        step();
        in_valid = 1'b0;
        step();
        n_cmp++; if (occ4 !== 2'd1) begin n_fail++; $display("FAIL bubble_occ1: got %0d, expected 1", occ4); end
        n_cmp++; if (ov4 !== 1'b1)  begin n_fail++; $display("FAIL bubble_valid: got %b, expected 1", ov4); end
        in_valid = 1'b1;
        sel_in   = 2'd3;
        inv_in   = 1'b1;
        #1;
        n_cmp++; if (rdy4 !== 1'b1) begin n_fail++; $display("FAIL bubble_ready: got %b, expected 1", rdy4); end
        step();
        in_valid = 1'b0;
        inv_in   = 1'b0;
        n_cmp++; if (occ4 !== 2'd2) begin n_fail++; $display("FAIL bubble_occ2: got %0d, expected 2", occ4); end
        n_cmp++; if (d4 !== 8'h22)  begin n_fail++; $display("FAIL bubble_head: got %h, expected 22", d4); end
    endtask

    task automatic test_flush();
        n_cmp++; if (occ4 !== 2'd2) begin n_fail++; $display("FAIL flush_pre_occ: got %0d, expected 2", occ4); end
        flush_in  = 1'b1;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        sel_in    = 2'd0;
        #1;
        n_cmp++; if (rdy4 !== 1'b0) begin n_fail++; $display("FAIL flush_in_ready: got %b, expected 0", rdy4); end
        step();
        flush_in = 1'b0;
        in_valid = 1'b0;
        n_cmp++; if (occ4 !== 2'd0) begin n_fail++; $display("FAIL flush_occ: got %0d, expected 0", occ4); end
        n_cmp++; if (ov4 !== 1'b0)  begin n_fail++; $display("FAIL flush_valid: got %b, expected 0", ov4); end
        n_cmp++; if (d4 !== 8'h22)  begin n_fail++; $display("FAIL flush_data_hold: got %h, expected 22", d4); end
        n_cmp++; if (err4 !== 1'b0) begin n_fail++; $display("FAIL flush_err4: got %b, expected 0", err4); end
        n_cmp++; if (err3 !== 1'b1) begin n_fail++; $display("FAIL flush_err3: got %b, expected 1", err3); end
        step();
        n_cmp++; if (ov4 !== 1'b0)  begin n_fail++; $display("FAIL flush_no_accept: got %b, expected 0", ov4); end
    endtask

    task automatic test_error_async_reset();
        do_reset();
        n_cmp++; if (err3 !== 1'b0) begin n_fail++; $display("FAIL err_pre: got %b, expected 0", err3); end
        out_ready = 1'b0;
        in_valid  = 1'b1;
        sel_in    = 2'd3;
        inv_in    = 1'b1;
        step();
        n_cmp++; if (err3 !== 1'b1) begin n_fail++; $display("FAIL err_set: got %b, expected 1", err3); end
        n_cmp++; if (err4 !== 1'b0) begin n_fail++; $display("FAIL err_in_range: got %b, expected 0", err4); end
        sel_in = 2'd0;
        inv_in = 1'b0;
        step();
        in_valid = 1'b0;
        n_cmp++; if (d3 !== 8'hFF)  begin n_fail++; $display("FAIL err_word: got %h, expected FF", d3); end
        n_cmp++; if (d4 !== 8'hBB)  begin n_fail++; $display("FAIL err_word4: got %h, expected BB", d4); end
        n_cmp++; if (err3 !== 1'b1) begin n_fail++; $display("FAIL err_sticky: got %b, expected 1", err3); end
        #1;
        rst = 1'b0;
        #1;
        n_cmp++; if (ov3 !== 1'b0)  begin n_fail++; $display("FAIL arst_valid: got %b, expected 0", ov3); end
        n_cmp++; if (occ3 !== 2'd0) begin n_fail++; $display("FAIL arst_occ: got %0d, expected 0", occ3); end
        n_cmp++; if (d3 !== 8'h00)  begin n_fail++; $display("FAIL arst_data: got %h, expected 00", d3); end
        n_cmp++; if (err3 !== 1'b0) begin n_fail++; $display("FAIL arst_err: got %b, expected 0", err3); end
        q4.delete();
        q3.delete();
        step();
        rst = 1'b1;
        out_ready = 1'b1;
        step();
        n_cmp++; if (ov4 !== 1'b0)  begin n_fail++; $display("FAIL arst_nodrain: got %b, expected 0", ov4); end
        n_cmp++; if (q4.size() != 0) begin n_fail++; $display("FAIL sb4_leftover: got %0d, expected 0", q4.size()); end
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        chv[0] = 8'h11; chv[1] = 8'h22; chv[2] = 8'h33; chv[3] = 8'h44;
        rst       = 1'b0;
        in_valid  = 1'b0;
        flush_in  = 1'b0;
        out_ready = 1'b0;
        sel_in    = 2'd0;
        inv_in    = 1'b0;
        test_reset();
        test_streaming();
        test_backpressure();
        test_bubble();
        test_flush();
        test_error_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/pmb_sel_pipe.md
Name: pmb_sel_pipe

Overview:
- Parametrised successor to the PMBIST flip-flop and 2:1 data-select primitives.
- Selects one of NCH data channels, optionally complements it (data-background inversion), and carries the result through a DEPTH-stage registered pipeline.
- Each stage has a valid/ready handshake with backpressure.
- Sits between the pattern generators and the memory write-data / compare-data path.

Parameters:
- DW, `DATA_WIDTH (8), width of each channel word
- NCH, 4, number of input channels (2..16)
- SELW, 2, width of sel_in; must satisfy 2**SELW >= NCH
- DEPTH, 2, number of pipeline register stages (1..8)
- CW, 2, width of occ_out; must satisfy 2**CW > DEPTH

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-low reset
- ch_data_in  input  NCH*DW  channel k occupies bits [k*DW +: DW]
- sel_in  input  SELW  channel select, sampled on accept
- inv_in  input  1  1 = complement the selected word, sampled on accept
- in_valid  input  1  upstream word valid
- in_ready  output  1  block can accept this cycle
- flush_in  input  1  synchronous pipeline clear
- d_out  output  DW  last-stage data
- out_valid  output  1  last-stage valid
- out_ready  input  1  downstream accepts
- occ_out  output  CW  number of valid stages
- err_out  output  1  sticky: an out-of-range select was accepted

Behaviour:
- Reset (rst=0, asynchronous): all stage valids=0, all stage data=0, err_out=0. Consequently out_valid=0, d_out=0, occ_out=0.
- Reset is released synchronously to clk by the surrounding logic.
- Reset asserted mid-transfer discards all in-flight words; nothing is drained.
- Stage data/valid: stage index 0 is the input stage, index DEPTH-1 is the output stage. Registers v[i] (valid) and q[i] (data).
- Advance enables (combinational): adv[DEPTH-1] = !v[DEPTH-1] | out_ready; adv[i] = !v[i] | adv[i+1].
- in_ready = adv[0] & !flush_in.
- Stage transfer on each clk edge, for every stage i with adv[i]=1:
  - i=0: v[0] <= in_valid & in_ready; q[0] <= the new word when accepted.
  - i>0: v[i] <= v[i-1]; q[i] <= q[i-1].
- Stages with adv[i]=0 hold both valid and data.
- Bubbles collapse: a stalled output still lets earlier empty stages fill.
- Data word = (sel_in < NCH ? channel[sel_in] : 0) XOR {DW{inv_in}}.
- Out-of-range select: err_out is set on the accept edge and stays set until reset. The word is still passed through (0, or all-ones if inv_in=1).
- Latency: with no backpressure, a word accepted at edge n appears with out_valid=1 after edge n+DEPTH-1. So DEPTH=1 gives out_valid in the cycle after accept. Throughput is one word per cycle.
- d_out = q[DEPTH-1]; out_valid = v[DEPTH-1].
- d_out holds its value while out_valid=1 and out_ready=0.
- d_out is don't-care-stable (holds last data) when out_valid=0.
- Flush (flush_in=1 at an edge): all v[i] <= 0; data registers hold; no input is accepted; any out_ready handshake in that cycle is ignored. Flush has priority over all transfers.
- occ_out = popcount(v), registered-equivalent (derived from the stage valids). Range is 0..DEPTH; full when occ_out=DEPTH and out_ready=0, which forces in_ready=0.
- Simultaneous accept and output with a full pipeline (out_ready=1): in_ready=1, and occupancy is unchanged.
- No combinational path from in_valid to out_valid. There is a combinational path from out_ready to in_ready (the ready chain).

Test Plan:
- Reset/idle: rst=0, then release → d_out=0, out_valid=0, occ_out=0, err_out=0, in_ready=1.
- Streaming, DEPTH=2, out_ready=1: ch0=8'h11, ch1=8'h22, ch2=8'h33, ch3=8'h44. Feed sel=0,1,2,3 on consecutive cycles with inv=0,0,1,0 → out_valid rises one cycle after the first accept; d_out sequence is 11,22,CC,44 on consecutive cycles.
- Backpressure: hold out_ready=0 and feed 3 words → the first 2 are accepted, in_ready=0, occ_out=2, d_out holds the first word. Raise out_ready for 1 cycle → first word retired, third word accepted, occ_out stays 2.
- Bubble collapse: put 1 word in stage 1 with out_ready=0, then present a word → it is accepted into stage 0 the next cycle, occ_out=2.
- Flush: pipeline full (occ_out=2), assert flush_in with in_valid=1 and out_ready=1 → next cycle occ_out=0, out_valid=0, no word accepted, err_out unchanged.
- Error and async reset: NCH=3, sel=3, inv=1 accepted → output word FF, err_out=1 thereafter. Then assert rst=0 mid-cycle → outputs clear immediately without waiting for clk.
